// File: rtl/cnt_readout_ctrl_if.sv
// Counter-block read port plus the valid/ready readout stream of cnt_readout_ctrl.
// The master side is the sequencer; the slave side is the counter block and the consumer.
interface cnt_readout_ctrl_if;
  logic       req;
  logic [2:0] idx;
  logic       cnt_valid;
  logic [7:0] cnt_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [2:0] rd_idx;

  modport master (
    output req, idx, rd_valid, rd_data, rd_idx,
    input  cnt_valid, cnt_data, rd_ready
  );

  modport slave (
    input  req, idx, rd_valid, rd_data, rd_idx,
    output cnt_valid, cnt_data, rd_ready
  );
endinterface

// File: rtl/cnt_readout_ctrl.sv
// Sweeps counters 0..NUM_CNT-1 and streams each count with a running total; one REQ cycle and
// at least one PUSH cycle per count, stalls indefinitely on missing cnt_valid or rd_ready.
module cnt_readout_ctrl #(
  parameter int NUM_CNT = 5
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                start,
  input  logic                IDLE,
  cnt_readout_ctrl_if.master  bus,
  output logic [10:0]         total,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_CNT - 1);

  typedef enum logic [1:0] {S_WAIT, S_REQ, S_PUSH, S_DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx_q;
  logic [7:0]  rd_data_q;
  logic [2:0]  rd_idx_q;
  logic [10:0] total_q;
  logic        take;
  logic        hs;

  // The counter block only answers while the system is idle, so a valid outside IDLE is stale.
  assign take = (state == S_REQ) && bus.cnt_valid && IDLE;
  assign hs   = (state == S_PUSH) && bus.rd_ready;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.req      = 1'b0;
    bus.rd_valid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_WAIT: begin
        busy = 1'b0;
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        bus.req = 1'b1;
        if (take) state_nxt = S_PUSH;
      end
      S_PUSH: begin
        bus.rd_valid = 1'b1;
        if (hs) state_nxt = (idx_q == LAST_IDX) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      idx_q     <= 3'd0;
      rd_data_q <= 8'd0;
      rd_idx_q  <= 3'd0;
      total_q   <= 11'd0;
    end else begin
      if ((state == S_WAIT) && start) begin
        idx_q   <= 3'd0;
        total_q <= 11'd0;
      end
      if (take) begin
        rd_data_q <= bus.cnt_data;
        rd_idx_q  <= idx_q;
        total_q   <= total_q + {3'b000, bus.cnt_data};
      end
      // idx parks on the last counter after the final handshake until the next start.
      if (hs && (idx_q != LAST_IDX)) idx_q <= idx_q + 3'd1;
    end
  end

  assign bus.idx     = idx_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_idx  = rd_idx_q;
  assign total       = total_q;

endmodule

// File: doc/cnt_readout_ctrl.md
# cnt_readout_ctrl

Sequencer that reads out the per-FIFO pop counters of the QoS_PCIE counter block and streams them to a downstream consumer. On a `start` pulse it walks the counter index from 0 to NUM_CNT-1. For each index it raises `req`, waits for the counter block's combinational `valid`, and captures the value. It presents each value on a valid/ready output port, accumulates the running total, and pulses `done` after the last count has been accepted. It sits between the test/control logic and the counter block, and is the only driver of that block's `req`/`idx` inputs.

## Interface
- NUM_CNT, 5, number of counters read per sweep (1..8)
- clk  in  1  system clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- start  in  1  single-cycle sweep request; ignored while `busy`
- IDLE  in  1  system idle flag; counter block only answers while high
- cnt_valid  in  1  `valid` from counter block
- cnt_data  in  8  `data_out` from counter block
- req  out  1  read request to counter block
- idx  out  3  counter index to counter block
- rd_valid  out  1  `rd_data` holds a captured count
- rd_ready  in  1  consumer accepts `rd_data` when `rd_valid && rd_ready`
- rd_data  out  8  captured count
- rd_idx  out  3  index of the count in `rd_data`
- total  out  11  sum of counts accepted in current/last sweep (max 8*255)
- busy  out  1  high in any state except WAIT
- done  out  1  one-cycle pulse at sweep completion

## Operation
- FSM states: WAIT, REQ, PUSH, DONE.
- WAIT: `req`=0, `busy`=0.
  - `start`=1 → REQ, with `idx`←0 and `total`←0.
- REQ: `req`=1, `idx` is driven from a register.
  - At the clock edge with `cnt_valid`=1: `rd_data`←`cnt_data`, `rd_idx`←`idx`, `total`←`total`+`cnt_data`; go to PUSH.
  - `cnt_valid`=0 (e.g. IDLE low): stay in REQ with `req` held; this is an unbounded stall and no data is captured.
- PUSH: `req`=0, `rd_valid`=1; `rd_data`/`rd_idx` held stable until accepted.
  - On `rd_valid && rd_ready` with `idx`==NUM_CNT-1: go to DONE.
  - Otherwise: `idx`←`idx`+1, go to REQ.
- DONE: `done`=1 for exactly one cycle, then WAIT. `total` holds its value until the next accepted `start`.
- `start` asserted in any state other than WAIT has no effect and is not queued.
- `idx` never exceeds NUM_CNT-1 and never wraps within a sweep.
- `total` is an 11-bit unsigned sum with zero-extended `cnt_data`; it cannot overflow for NUM_CNT≤8.
- `cnt_valid` outside REQ is ignored.

## Timing
- Reset (async, while `reset_L`=0):
  - state=WAIT
  - `req`=0, `idx`=0, `rd_valid`=0, `rd_data`=0, `rd_idx`=0
  - `total`=0, `busy`=0, `done`=0
- Reset asserted mid-sweep aborts the sweep immediately. There is no partial `done`, and `rd_valid` drops asynchronously.
- All outputs are registered or decoded from state only. There is no combinational path from `rd_ready`, `cnt_valid`, or `cnt_data` to any output.
- `start` sampled at edge N → `req`=1, `idx`=0 from cycle N+1.
- In REQ with `cnt_valid` high in the same cycle: capture at the end of that cycle, `rd_valid`=1 from the next cycle. This is 1 cycle of REQ per count.
- PUSH lasts ≥1 cycle, and 1 cycle if `rd_ready` is already high.
- Best-case sweep (IDLE=1, `rd_ready`=1): 2·NUM_CNT cycles in REQ/PUSH, then 1 DONE cycle.
  - For NUM_CNT=5, `start` at edge 0 gives `done` high in cycle 11.
- The last handshake and the DONE entry happen on the same edge; `rd_valid` and `done` are never high together.

## Test plan
- Reset release, no `start` for 20 cycles → `req`=0, `busy`=0, `rd_valid`=0, `total`=0 throughout.
- Counters preloaded to 3,7,0,31,12, IDLE=1, `rd_ready`=1, `start` pulse → `rd_data`/`rd_idx` sequence (3,0),(7,1),(0,2),(31,3),(12,4). `idx` values 0..4 appear only with `req`=1. `done` in cycle 11 with `total`=53.
- Same counters, `rd_ready` low for 4 cycles at each PUSH → `rd_data` stable while stalled, no extra `req`. `done` in cycle 31, `total`=53.
- IDLE forced low for 6 cycles while in REQ for idx 2 → `req`=1 and `idx`=2 held with no capture. Sweep resumes when IDLE returns, with the final `total` unchanged at 53.
- Second `start` pulses while `busy` → ignored, exactly 5 handshakes and one `done`. A new `start` after `done` resets `total` to 0 before accumulating.
- `reset_L` pulsed low during PUSH of idx 3 → `rd_valid`/`req`/`busy` drop immediately, `total`=0, no `done`. A following `start` begins at idx 0.
